// File: rtl/zpu_sd_multi_bridge.sv
// zpu_sd_multi_bridge
//
// Bridge between the ZPU firmware I/O registers and the hps_io sector-buffer
// interface. It serves several image slots (cart, disk, cassette, ...) through
// one shared sector buffer.
//
// The block owns:
//   - the sector buffer (dual-port RAM)
//   - the LBA latch
//   - a single request engine shared by all slots
//   - the io_done flag
//   - per-slot mount bookkeeping
//
// Parameters:
//   SLOTS  : number of hps_io image slots, 1..8
//   BUF_AW : sector buffer address width (2^BUF_AW bytes)
//
// Optional feature macro: ZPU_SD_WRITE_EN
//   defined   : block_wr requests are honoured; readonly follows img_readonly
//   undefined : sd_wr stays 0 and readonly reads 1. The hps_io read path
//               (port A) still works.
//
// Ports:
//   clk_sys, reset          system clock, asynchronous active-high reset
//   zpu_out2                [0] lba_sel, [1] block_rd, [2] block_wr,
//                           [3+:SW] slot select
//   zpu_out3                write data byte, or LBA value when lba_sel=1
//   zpu_io_wr               level; holds the ZPU buffer address at 0
//   zpu_data_wr/zpu_data_rd ZPU data strobes (levels, edge-detected here)
//   zpu_in2                 {readonly, filetype, fileno, mounted_tgl, io_done}
//   zpu_in3                 lba_sel ? filesize[slot] : buffer byte
//   img_mounted/img_readonly/img_size/ioctl_index
//                           mount information from hps_io
//   sd_lba, sd_rd, sd_wr, sd_ack
//                           block request handshake with hps_io
//   sd_buff_addr/dout/wr/din
//                           hps_io side of the sector buffer
module zpu_sd_multi_bridge #(
    parameter int SLOTS  = 4,
    parameter int BUF_AW = 9
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [31:0]       zpu_out2,
    input  logic [31:0]       zpu_out3,
    input  logic              zpu_io_wr,
    input  logic              zpu_data_wr,
    input  logic              zpu_data_rd,
    output logic [7:0]        zpu_in2,
    output logic [31:0]       zpu_in3,
    input  logic [SLOTS-1:0]  img_mounted,
    input  logic              img_readonly,
    input  logic [63:0]       img_size,
    input  logic [7:0]        ioctl_index,
    output logic [31:0]       sd_lba,
    output logic [SLOTS-1:0]  sd_rd,
    output logic [SLOTS-1:0]  sd_wr,
    input  logic [SLOTS-1:0]  sd_ack,
    input  logic [BUF_AW-1:0] sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    input  logic              sd_buff_wr,
    output logic [7:0]        sd_buff_din
);

    localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int NS    = 1 << SW;       // slot field decode range
    localparam int DEPTH = 1 << BUF_AW;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

    // ------------------------------------------------------------------
    // Register field decode
    // ------------------------------------------------------------------
    logic          lba_sel;
    logic [SW-1:0] slot_field;
    logic [NS-1:0] slot_onehot;

    assign lba_sel     = zpu_out2[0];
    assign slot_field  = zpu_out2[3 +: SW];
    assign slot_onehot = NS'(1) << slot_field;

    // ------------------------------------------------------------------
    // ZPU strobes, buffer address and LBA latch
    // ------------------------------------------------------------------
    logic              wr_d1_reg, wr_d2_reg;
    logic              zwr_strobe_reg, zinc_reg;
    logic [7:0]        zwr_data_reg;
    logic              rd_d1_reg;
    logic [BUF_AW-1:0] zaddr_reg;
    logic [31:0]       sd_lba_reg;
    logic              wr_rise, rd_fall;

    assign wr_rise = wr_d1_reg & ~wr_d2_reg;
    assign rd_fall = rd_d1_reg & ~zpu_data_rd;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_d1_reg      <= 1'b0;
            wr_d2_reg      <= 1'b0;
            zwr_strobe_reg <= 1'b0;
            zinc_reg       <= 1'b0;
            zwr_data_reg   <= 8'h00;
            rd_d1_reg      <= 1'b0;
            zaddr_reg      <= '0;
            sd_lba_reg     <= 32'h0;
        end else begin
            wr_d1_reg      <= zpu_data_wr;
            wr_d2_reg      <= wr_d1_reg;
            rd_d1_reg      <= zpu_data_rd;
            // The write strobe is one cycle long. The address advances
            // on the cycle after it, so the RAM write uses the old address.
            zwr_strobe_reg <= wr_rise & ~lba_sel;
            zinc_reg       <= zwr_strobe_reg;
            if (wr_rise & ~lba_sel) begin
                zwr_data_reg <= zpu_out3[7:0];
            end
            if (wr_rise & lba_sel) begin
                sd_lba_reg <= zpu_out3;
            end
            if (zpu_io_wr) begin
                zaddr_reg <= '0;
            end else if (zinc_reg) begin
                zaddr_reg <= zaddr_reg + BUF_AW'(1);
            end else if (rd_fall) begin
                zaddr_reg <= zaddr_reg + BUF_AW'(1);
            end
        end
    end

    assign sd_lba = sd_lba_reg;

    // ------------------------------------------------------------------
    // Sector buffer: port A = hps_io, port B = ZPU. Both reads are registered.
    // ------------------------------------------------------------------
    logic [7:0] mem_reg [DEPTH];
    logic [7:0] sd_buff_din_reg;
    logic [7:0] zdout_reg;

    always_ff @(posedge clk_sys) begin
        if (sd_buff_wr) begin
            mem_reg[sd_buff_addr] <= sd_buff_dout;
        end
        if (zwr_strobe_reg) begin
            mem_reg[zaddr_reg] <= zwr_data_reg;
        end
        sd_buff_din_reg <= mem_reg[sd_buff_addr];
        zdout_reg       <= mem_reg[zaddr_reg];
    end

    assign sd_buff_din = sd_buff_din_reg;

    // ------------------------------------------------------------------
    // Block request edge detection.
    // The edge is registered once more, so a request starts two edges
    // after block_rd/block_wr is first sampled high.
    // ------------------------------------------------------------------
    logic             blk_rd_d1_reg, blk_rd_d2_reg, rd_evt_reg;
    logic             wr_evt;
    logic [SLOTS-1:0] ack_d1_reg;
    logic [NS-1:0]    ack_pad;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            blk_rd_d1_reg <= 1'b0;
            blk_rd_d2_reg <= 1'b0;
            rd_evt_reg    <= 1'b0;
            ack_d1_reg    <= '0;
        end else begin
            blk_rd_d1_reg <= zpu_out2[1];
            blk_rd_d2_reg <= blk_rd_d1_reg;
            rd_evt_reg    <= blk_rd_d1_reg & ~blk_rd_d2_reg;
            ack_d1_reg    <= sd_ack;
        end
    end

`ifdef ZPU_SD_WRITE_EN
    logic blk_wr_d1_reg, blk_wr_d2_reg, wr_evt_reg;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            blk_wr_d1_reg <= 1'b0;
            blk_wr_d2_reg <= 1'b0;
            wr_evt_reg    <= 1'b0;
        end else begin
            blk_wr_d1_reg <= zpu_out2[2];
            blk_wr_d2_reg <= blk_wr_d1_reg;
            wr_evt_reg    <= blk_wr_d1_reg & ~blk_wr_d2_reg;
        end
    end

    assign wr_evt = wr_evt_reg;
`else
    assign wr_evt = 1'b0;
`endif

    // Pad the acknowledge vector to the full decode range, so that
    // indexing by cur_slot never goes out of range.
    assign ack_pad = NS'(ack_d1_reg);

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [SW-1:0]    cur_slot_reg, cur_slot_next;
    logic [SLOTS-1:0] sd_rd_reg, sd_rd_next;
    logic [SLOTS-1:0] sd_wr_reg, sd_wr_next;
    logic             io_done_reg, io_done_next;
    logic             slot_ok;

    // A slot number beyond SLOTS-1 would wait forever for an ack,
    // so such requests are not started.
    assign slot_ok = (32'(slot_field) < SLOTS);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cur_slot_reg <= '0;
            sd_rd_reg    <= '0;
            sd_wr_reg    <= '0;
            io_done_reg  <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cur_slot_reg <= cur_slot_next;
            sd_rd_reg    <= sd_rd_next;
            sd_wr_reg    <= sd_wr_next;
            io_done_reg  <= io_done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cur_slot_next = cur_slot_reg;
        sd_rd_next    = sd_rd_reg;
        sd_wr_next    = sd_wr_reg;
        io_done_next  = io_done_reg;
        case (state_reg)
            S_IDLE: begin
                // Read wins when both edges arrive together.
                if ((rd_evt_reg | wr_evt) & slot_ok) begin
                    cur_slot_next = slot_field;
                    io_done_next  = 1'b0;
                    state_next    = S_REQ;
                    if (rd_evt_reg) begin
                        sd_rd_next = slot_onehot[SLOTS-1:0];
                    end else begin
                        sd_wr_next = slot_onehot[SLOTS-1:0];
                    end
                end
            end
            S_REQ: begin
                if (ack_pad[cur_slot_reg]) begin
                    sd_rd_next = '0;
                    sd_wr_next = '0;
                    state_next = S_XFER;
                end
            end
            S_XFER: begin
                if (!ack_pad[cur_slot_reg]) begin
                    io_done_next = 1'b1;
                    state_next   = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign sd_rd = sd_rd_reg;

    // ------------------------------------------------------------------
    // Mount bookkeeping
    // ------------------------------------------------------------------
    logic [SLOTS-1:0]     mnt_d1_reg, mnt_d2_reg, mnt_rise;
    logic                 mnt_any;
    logic [SW-1:0]        mnt_idx;
    logic [2:0]           fileno_reg;
    logic [1:0]           filetype_reg;
    logic                 mounted_tgl_reg;
    logic                 first_reg;
    logic                 readonly;
    logic [NS-1:0][31:0]  filesize_all;

    assign mnt_rise = mnt_d1_reg & ~mnt_d2_reg;

    // Lowest rising index wins; simultaneous higher mounts are dropped.
    always_comb begin
        mnt_any = 1'b0;
        mnt_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (mnt_rise[i]) begin
                mnt_any = 1'b1;
                mnt_idx = SW'(i);
            end
        end
    end

    // The filesize registers have no reset, so image sizes survive a core reset.
    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_fsize
            if (gi < SLOTS) begin : g_slot
                logic [31:0] size_reg;
                always_ff @(posedge clk_sys) begin
                    if (mnt_any && (mnt_idx == SW'(gi))) begin
                        size_reg <= img_size[31:0];
                    end
                end
                assign filesize_all[gi] = size_reg;
            end else begin : g_pad
                assign filesize_all[gi] = 32'h0;
            end
        end
    endgenerate

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mnt_d1_reg      <= '0;
            mnt_d2_reg      <= '0;
            fileno_reg      <= 3'd0;
            filetype_reg    <= 2'd0;
            mounted_tgl_reg <= 1'b0;
            first_reg       <= 1'b1;
        end else begin
            mnt_d1_reg <= img_mounted;
            mnt_d2_reg <= mnt_d1_reg;
            first_reg  <= 1'b0;
            if (first_reg) begin
                // After reset, signal a mount to firmware if slot 0
                // still holds an image from before the reset.
                mounted_tgl_reg <= |filesize_all[0];
            end else if (mnt_any) begin
                fileno_reg      <= 3'(mnt_idx);
                filetype_reg    <= ioctl_index[7:6];
                mounted_tgl_reg <= ~mounted_tgl_reg;
            end
        end
    end

`ifdef ZPU_SD_WRITE_EN
    logic readonly_reg;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            readonly_reg <= 1'b1;
        end else if (!first_reg && mnt_any) begin
            readonly_reg <= img_readonly;
        end
    end

    assign readonly = readonly_reg;
    assign sd_wr    = sd_wr_reg;
`else
    assign readonly = 1'b1;
    assign sd_wr    = '0;
`endif

    // ------------------------------------------------------------------
    // ZPU read-back registers
    // ------------------------------------------------------------------
    assign zpu_in2 = {readonly, filetype_reg, fileno_reg, mounted_tgl_reg, io_done_reg};
    assign zpu_in3 = lba_sel ? filesize_all[slot_field] : {24'h0, zdout_reg};

    // Input bits with no function in this block.
    logic unused_bits;
`ifdef ZPU_SD_WRITE_EN
    assign unused_bits = ^{1'b0, zpu_out2[31:3+SW], ioctl_index[5:0], img_size[63:32]};
`else
    assign unused_bits = ^{1'b0, zpu_out2[31:3+SW], zpu_out2[2], ioctl_index[5:0],
                           img_size[63:32], img_readonly, sd_wr_reg};
`endif

endmodule

// File: tb/tb_zpu_sd_multi_bridge.sv
module tb_zpu_sd_multi_bridge;

    localparam int SLOTS  = 4;
    localparam int BUF_AW = 9;

`ifdef ZPU_SD_WRITE_EN
    localparam bit WREN = 1'b1;
`else
    localparam bit WREN = 1'b0;
`endif

    logic              clk_sys = 1'b0;
    logic              reset;
    logic [31:0]       zpu_out2, zpu_out3;
    logic              zpu_io_wr, zpu_data_wr, zpu_data_rd;
    logic [7:0]        zpu_in2;
    logic [31:0]       zpu_in3;
    logic [SLOTS-1:0]  img_mounted;
    logic              img_readonly;
    logic [63:0]       img_size;
    logic [7:0]        ioctl_index;
    logic [31:0]       sd_lba;
    logic [SLOTS-1:0]  sd_rd, sd_wr, sd_ack;
    logic [BUF_AW-1:0] sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic              sd_buff_wr;
    logic [7:0]        sd_buff_din;

    zpu_sd_multi_bridge #(.SLOTS(SLOTS), .BUF_AW(BUF_AW)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .zpu_out2(zpu_out2), .zpu_out3(zpu_out3),
        .zpu_io_wr(zpu_io_wr), .zpu_data_wr(zpu_data_wr), .zpu_data_rd(zpu_data_rd),
        .zpu_in2(zpu_in2), .zpu_in3(zpu_in3),
        .img_mounted(img_mounted), .img_readonly(img_readonly),
        .img_size(img_size), .ioctl_index(ioctl_index),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
            $display("check %-14s observed=%0h expected=%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic zpu_write(input logic [31:0] data);
        zpu_out3    = data;
        zpu_data_wr = 1'b1;
        repeat (2) tick();
        zpu_data_wr = 1'b0;
        repeat (3) tick();
    endtask

    task automatic zpu_read_pulse();
        zpu_data_rd = 1'b1;
        tick();
        zpu_data_rd = 1'b0;
        tick();
    endtask

    task automatic io_wr_pulse();
        zpu_io_wr = 1'b1;
        tick();
        zpu_io_wr = 1'b0;
        tick();
    endtask

    task automatic hps_read(input logic [BUF_AW-1:0] a, input logic [7:0] v, input string tag);
        sd_buff_addr = a;
        expect_val(tag, {24'h0, v});
        tick();
        check({24'h0, sd_buff_din});
    endtask

    task automatic ack_cycle(input logic [SLOTS-1:0] a);
        sd_ack = a;
        repeat (3) tick();
        sd_ack = '0;
        repeat (2) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ro_exp;

        reset = 1'b1; zpu_out2 = 0; zpu_out3 = 0; zpu_io_wr = 0;
        zpu_data_wr = 0; zpu_data_rd = 0; img_mounted = 0; img_readonly = 0;
        img_size = 0; ioctl_index = 0; sd_ack = 0; sd_buff_addr = 0;
        sd_buff_dout = 0; sd_buff_wr = 0;
        repeat (2) tick();

        // Reset state
        expect_val("rst_sd_rd", 0);     check(32'(sd_rd));
        expect_val("rst_sd_wr", 0);     check(32'(sd_wr));
        expect_val("rst_sd_lba", 0);    check(sd_lba);
        expect_val("rst_in2", 32'h81);  check(32'(zpu_in2));
        reset = 1'b0;
        tick();

        // Mount slot 0 so filesize[0] is known before the next reset
        img_size = 64'h100; ioctl_index = 8'h80; img_readonly = 1'b1;
        img_mounted = 4'b0001;
        repeat (3) tick();
        expect_val("mnt0_in2", 32'hC1); check(32'(zpu_in2 & 8'hFD));
        zpu_out2 = 32'h01; #1;
        expect_val("mnt0_size", 32'h100); check(zpu_in3);
        img_mounted = 0; zpu_out2 = 0;
        tick();

        // Reset: mounted_tgl follows |filesize[0]
        reset = 1'b1; tick(); reset = 1'b0; tick();
        expect_val("rst_tgl_in2", 32'h83); check(32'(zpu_in2));

        // Buffer writes from ZPU
        io_wr_pulse();
        zpu_write(32'hA5); zpu_write(32'h5A); zpu_write(32'h3C);
        hps_read(0, 8'hA5, "buf0");
        hps_read(1, 8'h5A, "buf1");
        hps_read(2, 8'h3C, "buf2_zaddr2");

        // ZPU read-back through zpu_in3
        zpu_io_wr = 1'b1; tick(); zpu_io_wr = 1'b0; tick();
        expect_val("zrd0", 32'hA5); check(zpu_in3);
        zpu_read_pulse(); tick();
        expect_val("zrd1", 32'h5A); check(zpu_in3);

        // Address wrap at 2^BUF_AW
        sd_buff_addr = 9'd511; sd_buff_dout = 8'hE1; sd_buff_wr = 1'b1; tick();
        sd_buff_wr = 1'b0;
        io_wr_pulse();
        for (int i = 0; i < 511; i++) zpu_read_pulse();
        tick();
        expect_val("zrd511", 32'hE1); check(zpu_in3);
        zpu_read_pulse(); tick();
        expect_val("zrd_wrap", 32'hA5); check(zpu_in3);

        // LBA write leaves buffer and address alone
        zpu_out2 = 32'h01;
        zpu_write(32'h0000_1234);
        expect_val("lba", 32'h1234); check(sd_lba);
        zpu_out2 = 0; tick();
        expect_val("lba_zbuf", 32'hA5); check(zpu_in3);
        hps_read(0, 8'hA5, "lba_buf0");

        // block_rd on slot 2
        zpu_out2 = 32'h12;
        tick(); expect_val("rd_lat1", 0); check(32'(sd_rd));
        tick(); expect_val("rd_lat2", 0); check(32'(sd_rd));
        tick(); expect_val("rd_req", 32'h4); check(32'(sd_rd));
        expect_val("rd_iodone0", 0); check(32'(zpu_in2[0]));
        zpu_out2 = 32'h10;
        sd_ack = 4'b0010; tick(); sd_ack = 0; repeat (2) tick();
        expect_val("ack_other", 32'h4); check(32'(sd_rd));
        zpu_out2 = 32'h0A; repeat (3) tick(); zpu_out2 = 32'h08; tick();
        expect_val("rd_busy_ign", 32'h4); check(32'(sd_rd));
        sd_ack = 4'b0100;
        tick(); expect_val("ack_lat", 32'h4); check(32'(sd_rd));
        tick(); expect_val("ack_drop", 0); check(32'(sd_rd));
        tick(); sd_ack = 0;
        tick(); expect_val("done_lat", 0); check(32'(zpu_in2[0]));
        tick(); expect_val("done_rise", 1); check(32'(zpu_in2[0]));
        zpu_out2 = 0; repeat (3) tick();
        expect_val("no_queue", 0); check(32'(sd_rd));

        // Simultaneous mounts on slots 1 and 2: slot 1 wins
        img_size = 64'hDEAD_0000_0000_2000; ioctl_index = 8'h40; img_readonly = 1'b0;
        img_mounted = 4'b0110;
        ro_exp = WREN ? 8'h00 : 8'h80;
        repeat (3) tick();
        expect_val("mnt_in2", 32'(ro_exp | 8'h25)); check(32'(zpu_in2));
        repeat (3) tick();
        expect_val("mnt_once", 32'(ro_exp | 8'h25)); check(32'(zpu_in2));
        zpu_out2 = 32'h09; #1;
        expect_val("size1", 32'h2000); check(zpu_in3);
        zpu_out2 = 32'h01; #1;
        expect_val("size0", 32'h100); check(zpu_in3);
        img_mounted = 0; zpu_out2 = 0; tick();

        // block_wr on slot 3
        zpu_out2 = 32'h1C; repeat (3) tick();
        expect_val("wr_req", WREN ? 32'h8 : 32'h0); check(32'(sd_wr));
        expect_val("wr_iodone", WREN ? 32'h0 : 32'h1); check(32'(zpu_in2[0]));
        zpu_out2 = 32'h18;
        ack_cycle(4'b1000);
        expect_val("wr_drop", 0); check(32'(sd_wr));
        expect_val("wr_done", 1); check(32'(zpu_in2[0]));

        // Both edges together on slot 0: read wins
        zpu_out2 = 32'h06; repeat (3) tick();
        expect_val("both_rd", 32'h1); check(32'(sd_rd));
        expect_val("both_wr", 0); check(32'(sd_wr));
        zpu_out2 = 0;
        ack_cycle(4'b0001);
        expect_val("both_done", 1); check(32'(zpu_in2[0]));

        // Reset during REQ
        zpu_out2 = 32'h0A; repeat (3) tick();
        expect_val("pre_rst_req", 32'h2); check(32'(sd_rd));
        reset = 1'b1; #1;
        expect_val("rst_drop", 0); check(32'(sd_rd));
        zpu_out2 = 0; tick(); reset = 1'b0; tick();
        expect_val("post_rst_in2", 32'h83); check(32'(zpu_in2));
        expect_val("post_rst_lba", 0); check(sd_lba);
        zpu_out2 = 32'h09; #1;
        expect_val("size1_kept", 32'h2000); check(zpu_in3);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left observed=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zpu_sd_multi_bridge.md
# zpu_sd_multi_bridge

Parametrised multi-slot bridge between the ZPU firmware I/O registers and the hps_io sector-buffer interface. It supersedes the single-image inline logic in the emu top level. It owns the shared sector buffer, the LBA latch, per-slot block read/write handshakes, the io_done flag and per-slot mount bookkeeping, so that cart, disk and cassette images can be served concurrently. It sits in the emu top level between hps_io and the core's ZPU_IN2/IN3, ZPU_OUT2/OUT3, ZPU_RD and ZPU_WR buses.

## Interface
Parameters:
- SLOTS, 4: number of hps_io image slots; legal range 1..8.
- BUF_AW, 9: sector buffer address width; the buffer holds 2^BUF_AW bytes.
- SW, derived: max(1, clog2(SLOTS)); width of the slot field.

Ports:
- clk_sys in 1: system clock.
- reset in 1: asynchronous, active-high.
- zpu_out2 in 32: [0] lba_sel, [1] block_rd, [2] block_wr, [3+:SW] slot select.
- zpu_out3 in 32: write data, or LBA value when lba_sel=1.
- zpu_io_wr in 1: level; while high, buffer address is forced to 0.
- zpu_data_wr in 1: data-write strobe (level; edge-detected).
- zpu_data_rd in 1: data-read strobe (level; edge-detected).
- zpu_in2 out 8: {readonly, filetype[1:0], fileno[2:0], mounted_tgl, io_done}.
- zpu_in3 out 32: lba_sel ? filesize[slot select] : {24'b0, buffer byte}.
- img_mounted in SLOTS: per-slot mount pulses from hps_io.
- img_readonly in 1: read-only flag from hps_io.
- img_size in 64: image size from hps_io.
- ioctl_index in 8: file type source; bits [7:6] are used.
- sd_lba out 32: sector address.
- sd_rd out SLOTS: per-slot read request.
- sd_wr out SLOTS: per-slot write request.
- sd_ack in SLOTS: per-slot acknowledge.
- sd_buff_addr in BUF_AW: hps_io side buffer address.
- sd_buff_dout in 8: hps_io side write data.
- sd_buff_wr in 1: hps_io side write enable.
- sd_buff_din out 8: hps_io side read data (registered).

## Operation
- Buffer: true dual-port RAM of 2^BUF_AW x 8.
  - Port A belongs to hps_io.
  - Port B belongs to the ZPU: address zaddr, data zpu_out3[7:0].
- zaddr update priority, highest first: zpu_io_wr forces 0; ZPU write increment; ZPU read increment. zaddr wraps modulo 2^BUF_AW.
- ZPU write: a rising edge of zpu_data_wr is detected through two flops (wr_d1, wr_d2); the condition is wr_d1 & ~wr_d2.
  - lba_sel=1: sd_lba <= zpu_out3.
  - lba_sel=0: one-cycle buffer write strobe; zaddr+1 on the cycle after the strobe.
- ZPU read: a falling edge of zpu_data_rd, detected with a single flop, increments zaddr.
- Request FSM, states IDLE, REQ, XFER:
  - IDLE: a rising edge of block_rd (or block_wr) latches cur_slot from the slot field. It then sets sd_rd[cur_slot] (or sd_wr[cur_slot]), sets io_done=0, and goes to REQ.
  - REQ: when sd_ack[cur_slot]=1, clear all sd_rd/sd_wr and go to XFER.
  - XFER: when sd_ack[cur_slot] falls, set io_done=1 and go to IDLE.
  - block_rd/block_wr edges outside IDLE are ignored and not queued.
  - If both edges occur in the same cycle, read wins.
  - sd_ack on any slot other than cur_slot is ignored.
- Mount: a rising edge on any img_mounted bit is handled; if several rise in the same cycle, the lowest index wins and the others are dropped. The following updates occur:
  - fileno <= index.
  - filetype <= ioctl_index[7:6].
  - readonly <= img_readonly.
  - filesize[index] <= img_size[31:0].
  - mounted_tgl toggles.
- filesize[] registers have no reset; they persist across reset.
- On the first clk_sys edge after reset deasserts: mounted_tgl <= |filesize[0].

## Timing
- Reset values:
  - sd_rd, sd_wr, sd_lba, zaddr, fileno, filetype, mounted_tgl: 0.
  - readonly: 1.
  - io_done: 1.
  - FSM: IDLE.
- Reset asserted mid-transfer drops the requests immediately; no io_done pulse follows.
- ZPU write path: zpu_data_wr first sampled high at edge N; RAM write at edge N+2; zaddr increments at edge N+3.
- sd_rd/sd_wr assert 2 edges after block_rd/block_wr is first sampled high.
- Requests drop 1 edge after sd_ack is sampled high.
- io_done rises 1 edge after the sd_ack falling edge is seen.
- zpu_in3 buffer byte is valid 1 cycle after a zaddr change; the filesize path is combinational on slot select.
- sd_buff_din: 1-cycle latency from sd_buff_addr.

## Configuration
- ZPU_SD_WRITE_EN defined:
  - block_wr is honoured.
  - readonly follows img_readonly.
- ZPU_SD_WRITE_EN undefined:
  - block_wr is ignored; sd_wr is tied to 0.
  - readonly is always 1.
  - The hps_io port-A read path still operates.

## Test plan
- io_wr pulse, then write 0xA5, 0x5A -> buffer[0]=0xA5, buffer[1]=0x5A, zaddr=2; hps_io reads 0xA5 at sd_buff_addr=0.
- lba_sel=1, zpu_out3=0x00001234, data_wr edge -> sd_lba=0x1234; buffer unchanged.
- Slot field=2, block_rd edge -> sd_rd=4'b0100, io_done=0. sd_ack[1] pulse -> no effect. sd_ack[2] high for 3 cycles -> sd_rd=0; io_done=1 one cycle after ack falls.
- img_mounted=4'b0110 with img_size=0x2000 and ioctl_index=0x40 -> fileno=1, filetype=1, filesize[1]=0x2000, mounted_tgl toggles once.
- block_wr edge with ZPU_SD_WRITE_EN undefined -> sd_wr stays 0 and io_done stays 1; with the macro defined -> sd_wr[slot]=1.
- Reset asserted during REQ -> sd_rd=0 immediately; after release mounted_tgl=|filesize[0], and filesize[1] is retained.
